i2s_rx: RTL
===========

Name: i2s_rx

Overview:
- I2S master-mode receiver for a slave ADC (CS5343-class) at 48 kHz.
- Generates mclk, sclk and lrclk from clk_i2s (12.288 MHz) and deserializes the stereo stream on rx_sd.
- Presents each left/right sample pair with a one-cycle valid strobe.
- Capture-side counterpart of the I2S transmit path; sits between the ADC pins and the audio processing logic.

Parameters:
- SCLK_DVSR, 4, clk_i2s cycles per sclk period. Power of 2, >=2. 12.288 MHz / 4 = 3.072 MHz = 64 x 48 kHz.
- SLOT_W, 32, sclk periods per channel slot. One frame = 2*SLOT_W sclk.
- DATA_W, 24, captured bits per channel, MSB-first. Must satisfy DATA_W <= SLOT_W-1.

Ports:
- clk_i2s, in, 1, 12.288 MHz clock. All logic is on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- rx_sd, in, 1, serial data from the ADC. Changes on sclk falling edge.
- rx_mclk, out, 1, equals clk_i2s directly.
- rx_sclk, out, 1, bit clock.
- rx_lrclk, out, 1, word select. 0 = left, 1 = right.
- rx_left, out, DATA_W, last complete left sample.
- rx_right, out, DATA_W, last complete right sample.
- rx_valid, out, 1, one-cycle pulse when rx_left/rx_right update.

Behaviour:
- Divider:
  - cnt runs 0..SCLK_DVSR-1 and wraps.
  - rx_sclk = (cnt >= SCLK_DVSR/2), so sclk is low in the first half of the period.
  - sclk_tick = (cnt == SCLK_DVSR-1).
- Frame counter:
  - fcnt runs 0..2*SLOT_W-1 and advances on sclk_tick, wrapping to 0.
  - rx_lrclk = (fcnt >= SLOT_W), registered or decoded so that it changes only at sclk falling edges.
  - Slot bit index b = fcnt mod SLOT_W.
- Sampling:
  - rx_sd is sampled in the cycle where cnt == SCLK_DVSR/2, i.e. the first cycle after the sclk rising edge.
  - No synchronizer: rx_sd is source-synchronous to sclk, which this block generates.
- I2S one-bit delay:
  - b=0 is ignored.
  - Bits b=1..DATA_W are shifted into a DATA_W shift register, MSB first.
  - Bits b > DATA_W are ignored, so shift register content is frozen.
  - The shift register clears at the start of each slot (b=0).
- Left slot end (sclk_tick with fcnt == SLOT_W-1): shift register is copied into an internal left hold register.
- Right slot end (sclk_tick with fcnt == 2*SLOT_W-1):
  - rx_left <= left hold, rx_right <= shift register, rx_valid <= 1, all on the same edge.
  - rx_valid is high for exactly one clk_i2s cycle, then 0.
  - Strobe period is 2*SLOT_W*SCLK_DVSR = 256 cycles.
- Output stability: rx_left/rx_right hold their value between strobes. Both update atomically, never separately.
- First frame:
  - rx_valid never fires for a frame whose left slot started before reset release.
  - The first strobe occurs at the end of the first full frame after reset.
  - Default first strobe: cycle 255 after release (0-indexed edge count), output visible in cycle 256.
- Reset, whenever asserted, including mid-frame:
  - cnt, fcnt, shift register and hold register are cleared.
  - rx_left = rx_right = 0, rx_valid = 0.
  - rx_sclk = 0, rx_lrclk = 0 (left).
  - Any partial frame is discarded, with no strobe.
  - rx_mclk keeps toggling.
- No backpressure: the consumer must take samples within 256 cycles or they are overwritten.

Test Plan:
- Reset, then release:
  - During reset all outputs are 0.
  - After release, rx_sclk has a period of 4 cycles (low 2 / high 2).
  - rx_lrclk has a period of 256 cycles (128 low, 128 high), toggling only on sclk falling edges.
- ADC model drives left=0xA5A5A5, right=0x5A5A5A in I2S format (MSB at b=1, data changing on sclk falling edge):
  - First rx_valid arrives 256 cycles after release, with exact values.
  - The pulse is 1 cycle wide, with subsequent pulses every 256 cycles.
- Junk bits: drive 1 on b=0 and b=25..31, with data bits 0 -> rx_left = rx_right = 0x000000.
- Extremes: left=0x800000, right=0x7FFFFF, then swapped next frame -> each strobe shows that frame's exact values.
- Reset for 3 cycles at fcnt=40 (right slot), after outputs held 0x123456/0x654321:
  - Outputs clear to 0 and no strobe occurs for the partial frame.
  - The next strobe arrives 256 cycles after release with new data.
- DATA_W=16 build, stream 0x1234AB per slot -> rx_left = rx_right = 0x1234. Trailing bits are ignored.

Source files
------------

// File: rtl/i2s_rx_if.sv
// Pin-side bundle of the I2S capture block: ADC serial data in, generated clocks
// and the deserialized stereo sample pair out.
interface i2s_rx_if #(
  parameter int DATA_W = 24
);
  logic              rx_sd;
  logic              rx_mclk;
  logic              rx_sclk;
  logic              rx_lrclk;
  logic [DATA_W-1:0] rx_left;
  logic [DATA_W-1:0] rx_right;
  logic              rx_valid;

  modport master (
    input  rx_sd,
    output rx_mclk, rx_sclk, rx_lrclk, rx_left, rx_right, rx_valid
  );

  modport slave (
    output rx_sd,
    input  rx_mclk, rx_sclk, rx_lrclk, rx_left, rx_right, rx_valid
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S master-mode receiver: derives sclk/lrclk from clk_i2s, deserializes the
// ADC stream and presents each completed left/right pair with a one-cycle strobe.
module i2s_rx #(
  parameter int SCLK_DVSR = 4,
  parameter int SLOT_W    = 32,
  parameter int DATA_W    = 24
)(
  input  logic     clk_i2s,
  input  logic     reset,
  i2s_rx_if.master bus
);
  localparam int CW = (SCLK_DVSR > 2) ? $clog2(SCLK_DVSR) : 1;
  localparam int FW = $clog2(2*SLOT_W);

  localparam logic [CW-1:0] CNT_MAX = CW'(SCLK_DVSR-1);
  localparam logic [CW-1:0] CNT_SMP = CW'(SCLK_DVSR/2);
  localparam logic [FW-1:0] F_LEND  = FW'(SLOT_W-1);
  localparam logic [FW-1:0] F_REND  = FW'(2*SLOT_W-1);
  localparam logic [FW-1:0] F_SLOT  = FW'(SLOT_W);
  localparam logic [FW-1:0] B_LAST  = FW'(DATA_W);

  logic [CW-1:0]     r_cnt;
  logic [FW-1:0]     r_fcnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_left;
  logic [DATA_W-1:0] r_right;
  logic              r_valid;

  logic          w_tick;
  logic          w_smp;
  logic          w_lr;
  logic [FW-1:0] w_bidx;
  logic          w_bit_en;
  logic          w_lend;
  logic          w_rend;

  assign w_tick   = (r_cnt == CNT_MAX);
  assign w_smp    = (r_cnt == CNT_SMP);
  assign w_lr     = (r_fcnt >= F_SLOT);
  assign w_bidx   = w_lr ? (r_fcnt - F_SLOT) : r_fcnt;
  // b=0 is the I2S one-bit delay; bits past DATA_W are padding
  assign w_bit_en = (w_bidx != '0) && (w_bidx <= B_LAST);
  assign w_lend   = w_tick && (r_fcnt == F_LEND);
  assign w_rend   = w_tick && (r_fcnt == F_REND);

  always_ff @(posedge clk_i2s) begin
    if (reset)       r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  // fcnt steps on the last clk of each sclk period, so lrclk flips with sclk's fall
  always_ff @(posedge clk_i2s) begin
    if (reset)       r_fcnt <= '0;
    else if (w_tick) r_fcnt <= (r_fcnt == F_REND) ? '0 : r_fcnt + 1'b1;
  end

  // rx_sd is launched by the ADC on sclk fall; sampling just after the rise gives
  // half a bit period of margin, and no synchronizer is needed since we own sclk
  always_ff @(posedge clk_i2s) begin
    if (reset) begin
      r_shift <= '0;
    end else if (w_smp) begin
      if (w_bidx == '0)  r_shift <= '0;
      else if (w_bit_en) r_shift <= {r_shift[DATA_W-2:0], bus.rx_sd};
    end
  end

  always_ff @(posedge clk_i2s) begin
    if (reset)       r_hold <= '0;
    else if (w_lend) r_hold <= r_shift;
  end

  // Left and right land together so the consumer never sees a torn pair
  always_ff @(posedge clk_i2s) begin
    if (reset) begin
      r_left  <= '0;
      r_right <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rend;
      if (w_rend) begin
        r_left  <= r_hold;
        r_right <= r_shift;
      end
    end
  end

  assign bus.rx_mclk  = clk_i2s;
  assign bus.rx_sclk  = (r_cnt >= CNT_SMP);
  assign bus.rx_lrclk = w_lr;
  assign bus.rx_left  = r_left;
  assign bus.rx_right = r_right;
  assign bus.rx_valid = r_valid;
endmodule
